// File: rtl/cpu_reg_file_if.sv
// cpu_reg_file_if: decode/writeback bus of the RV32 register file
// (write data/index/enable, two read indices, two read data words).
interface cpu_reg_file_if;
    logic [31:0] IN;
    logic [4:0]  INADDRESS;
    logic        WRITE_EN;
    logic [4:0]  OUT1ADDRESS;
    logic [4:0]  OUT2ADDRESS;
    logic [31:0] OUT1;
    logic [31:0] OUT2;
    modport master (
        output IN, INADDRESS, WRITE_EN, OUT1ADDRESS, OUT2ADDRESS,
        input  OUT1, OUT2
    );
    modport slave (
        input  IN, INADDRESS, WRITE_EN, OUT1ADDRESS, OUT2ADDRESS,
        output OUT1, OUT2
    );
endinterface

// File: rtl/cpu_reg_file.sv
// cpu_reg_file: 32x32 RV32 register file, two combinational reads, one synchronous write, x0 hardwired to 0.
// Define REG_FILE_BYPASS_EN for write-through forwarding of the in-flight write onto the read ports.
module cpu_reg_file (
    input logic           CLK,
    input logic           RESET,
    cpu_reg_file_if.slave bus
);
    logic [31:0] regs [32];
    logic        wr;
    assign wr = RESET && bus.WRITE_EN && bus.INADDRESS != 5'd0;
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (wr) begin
            regs[bus.INADDRESS] <= bus.IN;
        end
    end
    // x0 is masked on read, so its storage slot never matters
`ifdef REG_FILE_BYPASS_EN
    assign bus.OUT1 = bus.OUT1ADDRESS == 5'd0 ? '0 :
                      (wr && bus.OUT1ADDRESS == bus.INADDRESS) ? bus.IN : regs[bus.OUT1ADDRESS];
    assign bus.OUT2 = bus.OUT2ADDRESS == 5'd0 ? '0 :
                      (wr && bus.OUT2ADDRESS == bus.INADDRESS) ? bus.IN : regs[bus.OUT2ADDRESS];
`else
    assign bus.OUT1 = bus.OUT1ADDRESS == 5'd0 ? '0 : regs[bus.OUT1ADDRESS];
    assign bus.OUT2 = bus.OUT2ADDRESS == 5'd0 ? '0 : regs[bus.OUT2ADDRESS];
`endif
endmodule

// File: tb/tb_cpu_reg_file.sv
// tb_cpu_reg_file: directed vector table plus randomized traffic against an array model of the register file.
module tb_cpu_reg_file;
`ifdef REG_FILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    typedef struct {
        bit          rst;
        bit          we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [4:0]  a1;
        logic [4:0]  a2;
        logic [31:0] e1;
        logic [31:0] e2;
    } vec_t;

    logic CLK = 1'b0;
    logic RESET = 1'b1;
    cpu_reg_file_if bus();
    cpu_reg_file dut (.CLK(CLK), .RESET(RESET), .bus(bus));
    always #5 CLK = ~CLK;

    logic [31:0] mem [32];
    int n_vec = 0;
    int n_err = 0;
    vec_t tbl [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model_rd(input logic [4:0] a);
        if (a == 0) return '0;
        if (BYP && RESET && bus.WRITE_EN && bus.INADDRESS != 0 && bus.INADDRESS == a) return bus.IN;
        return mem[a];
    endfunction

    task automatic drive(input bit rst, input bit we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic [4:0] a1, input logic [4:0] a2);
        RESET = rst;
        bus.WRITE_EN = we;
        bus.INADDRESS = wa;
        bus.IN = wd;
        bus.OUT1ADDRESS = a1;
        bus.OUT2ADDRESS = a2;
        #1;
    endtask

    task automatic commit();
        @(posedge CLK);
        if (!RESET) for (int i = 0; i < 32; i++) mem[i] = '0;
        else if (bus.WRITE_EN && bus.INADDRESS != 0) mem[bus.INADDRESS] = bus.IN;
        @(negedge CLK);
    endtask

    initial begin
        tbl[0]  = '{0, 1, 5'd3, 32'hFFFF_FFFF, 5'd0, 5'd0, 32'h0, 32'h0};
        tbl[1]  = '{1, 1, 5'd0, 32'h0000_0002, 5'd0, 5'd0, 32'h0, 32'h0};
        tbl[2]  = '{1, 1, 5'd3, 32'hDEAD_BEEF, 5'd0, 5'd1, 32'h0, 32'h0};
        tbl[3]  = '{1, 1, 5'd1, 32'h0000_0002, 5'd3, 5'd2, 32'hDEAD_BEEF, 32'h0};
        tbl[4]  = '{1, 0, 5'd5, 32'h0000_1234, 5'd3, 5'd1, 32'hDEAD_BEEF, 32'h2};
        tbl[5]  = '{1, 0, 5'd0, 32'h0, 5'd5, 5'd2, 32'h0, 32'h0};
        tbl[6]  = '{0, 1, 5'd3, 32'hFFFF_FFFF, 5'd3, 5'd1, 32'hDEAD_BEEF, 32'h2};
        tbl[7]  = '{1, 1, 5'd7, 32'h0000_0055, 5'd3, 5'd7, 32'h0, BYP ? 32'h55 : 32'h0};
        tbl[8]  = '{1, 0, 5'd0, 32'h0, 5'd7, 5'd1, 32'h55, 32'h0};
        tbl[9]  = '{1, 1, 5'd7, 32'h0000_AAAA, 5'd7, 5'd7, BYP ? 32'hAAAA : 32'h55, BYP ? 32'hAAAA : 32'h55};
        tbl[10] = '{1, 0, 5'd0, 32'h0, 5'd7, 5'd0, 32'hAAAA, 32'h0};
        tbl[11] = '{1, 1, 5'd0, 32'h0000_0099, 5'd0, 5'd0, 32'h0, 32'h0};
        for (int i = 0; i < 32; i++) mem[i] = '0;
        @(negedge CLK);
        drive(1, 0, 5'd0, 32'h0, 5'd0, 5'd0);
        check("x0_before_reset_p1", bus.OUT1, 32'h0);
        check("x0_before_reset_p2", bus.OUT2, 32'h0);
        drive(0, 0, 5'd0, 32'h0, 5'd0, 5'd0);
        commit();
        for (int a = 0; a < 32; a++) begin
            drive(1, 0, 5'd0, 32'h0, 5'(a), 5'(31 - a));
            check($sformatf("reset_all_p1_x%0d", a), bus.OUT1, 32'h0);
            check($sformatf("reset_all_p2_x%0d", 31 - a), bus.OUT2, 32'h0);
        end
        for (int i = 0; i < 12; i++) begin
            drive(tbl[i].rst, tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].a1, tbl[i].a2);
            check($sformatf("tbl%0d_out1", i), bus.OUT1, tbl[i].e1);
            check($sformatf("tbl%0d_out2", i), bus.OUT2, tbl[i].e2);
            commit();
        end
        // mid-cycle reset assertion must not clear anything before the edge
        drive(1, 1, 5'd9, 32'h1357_9BDF, 5'd0, 5'd0);
        commit();
        drive(0, 0, 5'd0, 32'h0, 5'd9, 5'd7);
        check("reset_pending_x9", bus.OUT1, 32'h1357_9BDF);
        check("reset_pending_x7", bus.OUT2, 32'hAAAA);
        commit();
        drive(1, 0, 5'd0, 32'h0, 5'd9, 5'd7);
        check("reset_done_x9", bus.OUT1, 32'h0);
        check("reset_done_x7", bus.OUT2, 32'h0);
        for (int n = 0; n < 400; n++) begin
            logic [4:0] wa, a1, a2;
            wa = 5'($urandom_range(0, 31));
            a1 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
            a2 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
            drive($urandom_range(0, 24) != 0, $urandom_range(0, 2) != 0, wa, $urandom, a1, a2);
            check($sformatf("rnd%0d_out1", n), bus.OUT1, model_rd(a1));
            check($sformatf("rnd%0d_out2", n), bus.OUT2, model_rd(a2));
            commit();
        end
        for (int a = 0; a < 32; a++) begin
            drive(1, 0, 5'd0, 32'h0, 5'(a), 5'(a));
            check($sformatf("final_p1_x%0d", a), bus.OUT1, model_rd(5'(a)));
            check($sformatf("final_p2_x%0d", a), bus.OUT2, model_rd(5'(a)));
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
